// File: rtl/fc_argmax_ctrl.sv
// fc_argmax_ctrl: scans the FC3 output buffer (f8) and reports the index and value of
// the largest signed score as the predicted class. Owns the f8 read port while busy.
module fc_argmax_ctrl #(
  parameter int unsigned DW      = 16,
  parameter int unsigned N_CLASS = 10,
  parameter int unsigned AW      = 4,
  parameter int unsigned RD_LAT  = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          argmax_start,
  output logic          f8_rd_en,
  output logic [AW-1:0] f8_raddr,
  input  logic [DW-1:0] f8_rdata,
  output logic [AW-1:0] class_id,
  output logic [DW-1:0] class_score,
  output logic          argmax_busy,
  output logic          argmax_done
);

  localparam logic [AW-1:0] LastIdx = AW'(N_CLASS - 1);

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

  state_e state_q;

  // Read-valid / index delay line, aligned with the buffer's read latency
  logic [RD_LAT-1:0] vld_pipe_q;
  logic [AW-1:0]     idx_pipe_q [RD_LAT];

  logic          smp_vld;
  logic [AW-1:0] smp_idx;

  // Running maximum over the samples seen so far in this scan
  logic [DW-1:0] max_q, max_d;
  logic [AW-1:0] idx_q, idx_d;

  assign smp_vld = vld_pipe_q[RD_LAT-1];
  assign smp_idx = idx_pipe_q[RD_LAT-1];

  // Delay rd_en/address by RD_LAT so each returning word is tagged with its index
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      for (int i = 0; i < RD_LAT; i++) idx_pipe_q[i] <= '0;
    end else begin
      vld_pipe_q[0] <= f8_rd_en;
      idx_pipe_q[0] <= f8_raddr;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        idx_pipe_q[i] <= idx_pipe_q[i-1];
      end
    end
  end

  // Compare rule: index 0 seeds the max; later entries win only if strictly greater,
  // so ties keep the lower index
  always_comb begin
    max_d = max_q;
    idx_d = idx_q;
    if (smp_vld) begin
      if (smp_idx == '0) begin
        max_d = f8_rdata;
        idx_d = '0;
      end else if ($signed(f8_rdata) > $signed(max_q)) begin
        max_d = f8_rdata;
        idx_d = smp_idx;
      end
    end
  end

  // Running max registers
  always_ff @(posedge clk) begin
    if (rst) begin
      max_q <= '0;
      idx_q <= '0;
    end else begin
      max_q <= max_d;
      idx_q <= idx_d;
    end
  end

  // Scan FSM with registered outputs; results load on the edge into DONE using the
  // final compare so they are valid together with argmax_done
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      f8_rd_en    <= 1'b0;
      f8_raddr    <= '0;
      class_id    <= '0;
      class_score <= '0;
      argmax_busy <= 1'b0;
      argmax_done <= 1'b0;
    end else begin
      argmax_done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (argmax_start) begin
            state_q     <= StRead;
            f8_rd_en    <= 1'b1;
            f8_raddr    <= '0;
            argmax_busy <= 1'b1;
          end
        end
        StRead: begin
          if (f8_raddr == LastIdx) begin
            state_q  <= StDrain;
            f8_rd_en <= 1'b0;
            f8_raddr <= '0;
          end else begin
            f8_raddr <= f8_raddr + 1'b1;
          end
        end
        StDrain: begin
          if (smp_vld && (smp_idx == LastIdx)) begin
            state_q     <= StDone;
            argmax_busy <= 1'b0;
            argmax_done <= 1'b1;
            class_id    <= idx_d;
            class_score <= max_d;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
